// File: rtl/keypad_pkg.sv
// Keypad scan controller shared types, key map and column helpers.
// Used by keypad_scan_ctrl and its scan timer.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_t;

  localparam logic [3:0] COLS_IDLE = 4'hF;

  // Indexed {row, col}; column 0 is cols[0].
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // True when exactly one column is pulled low.
  function automatic logic single_low(input logic [3:0] c);
    logic [3:0] z;
    z = ~c;
    return (z != 4'h0) && ((z & (z - 4'h1)) == 4'h0);
  endfunction

  // Position of the low column (meaningful only for single_low).
  function automatic logic [1:0] low_idx(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!c[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_scan_timer.sv
// Scan tick generator: one-cycle tick every TICK_DIV clocks.
// Ports: clk, reset (async, active-high), tick (out).
module scan_timer #(
  parameter int TICK_DIV = 48000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row sequencing, press/release debounce over
// scan ticks, one-entry valid/ready key buffer with overrun pulse.
// Ports: clk, reset; cols in (active-low); rows out (active-low);
// keyCode/keyValid/keyReady handshake; overrun pulse.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = 48000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] keyCode,
  output logic       keyValid,
  input  logic       keyReady,
  output logic       overrun
);

  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  logic        tick;
  logic [3:0]  sync1;
  logic [3:0]  colsS;
  scan_state_t state, state_n;
  logic [1:0]  rowIdx, rowIdx_n;
  logic [1:0]  latRow, latRow_n;
  logic [3:0]  latCols, latCols_n;
  logic [3:0]  dbCnt, dbCnt_n;
  logic        commit;
  logic [3:0]  code;
  logic        xfer;

  scan_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= COLS_IDLE;
      colsS <= COLS_IDLE;
    end else begin
      sync1 <= cols;
      colsS <= sync1;
    end
  end

  always_comb begin
    state_n   = state;
    rowIdx_n  = rowIdx;
    latRow_n  = latRow;
    latCols_n = latCols;
    dbCnt_n   = dbCnt;
    commit    = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (single_low(colsS)) begin
            latRow_n  = rowIdx;
            latCols_n = colsS;
            dbCnt_n   = 4'd1;
            if (DB == 4'd1) begin
              commit  = 1'b1;
              state_n = HELD;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            rowIdx_n = rowIdx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (colsS == latCols) begin
            dbCnt_n = dbCnt + 4'd1;
            if (dbCnt_n == DB) begin
              commit  = 1'b1;
              state_n = HELD;
            end
          end else begin
            state_n  = SCAN;
            rowIdx_n = rowIdx + 2'd1;
          end
        end
        HELD: begin
          if (colsS == COLS_IDLE) begin
            dbCnt_n = 4'd1;
            if (DB == 4'd1) begin
              state_n  = SCAN;
              rowIdx_n = rowIdx + 2'd1;
            end else begin
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (colsS == COLS_IDLE) begin
            dbCnt_n = dbCnt + 4'd1;
            if (dbCnt_n == DB) begin
              state_n  = SCAN;
              rowIdx_n = rowIdx + 2'd1;
            end
          end else begin
            state_n = HELD;
          end
        end
      endcase
    end
  end

  // Next-latch values cover the single-tick commit from SCAN.
  assign code = KEYMAP[{latRow_n, low_idx(latCols_n)}];
  assign xfer = keyValid & keyReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SCAN;
      rowIdx  <= 2'd0;
      rows    <= 4'b1110;
      latRow  <= 2'd0;
      latCols <= COLS_IDLE;
      dbCnt   <= 4'd0;
    end else begin
      state   <= state_n;
      rowIdx  <= rowIdx_n;
      rows    <= ~(4'b0001 << rowIdx_n);
      latRow  <= latRow_n;
      latCols <= latCols_n;
      dbCnt   <= dbCnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keyValid <= 1'b0;
      keyCode  <= 4'h0;
      overrun  <= 1'b0;
    end else begin
      overrun <= commit & keyValid & ~xfer;
      if (commit && (!keyValid || xfer)) begin
        keyValid <= 1'b1;
        keyCode  <= code;
      end else if (xfer) begin
        keyValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with an emulated keypad
// matrix and a tick-level behavioural model.
module tb_keypad_scan_ctrl;

  localparam int TD = 8;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        keyReady = 1'b0;
  logic [15:0] keys = 16'h0;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        overrun;

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[4*r+c]) cols[c] = 1'b0;
  end

  keypad_scan_ctrl #(
    .TICK_DIV(TD),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cols    (cols),
    .rows    (rows),
    .keyCode (keyCode),
    .keyValid(keyValid),
    .keyReady(keyReady),
    .overrun (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  string keymap_s = "123A456B789CE0FD";

  function automatic logic [3:0] keyval(input int row, input logic [3:0] pat);
    int  col;
    byte ch;
    col = 0;
    for (int i = 0; i < 4; i++)
      if (!pat[i]) col = i;
    ch = keymap_s[row*4+col];
    if (ch >= 8'h30 && ch <= 8'h39) return 4'(ch - 8'h30);
    return 4'(ch - 8'h41 + 10);
  endfunction

  function automatic logic [3:0] row_drive(input int r);
    logic [3:0] f;
    f = 4'hF;
    f[r] = 1'b0;
    return f;
  endfunction

  // mmode: 0 searching, 1 confirming press, 2 key down, 3 confirming release
  int         mcnt, mrow, mmode, mrun, mlat_row;
  logic [3:0] mlat, ms1, ms2, mcode;
  logic       mvalid, movr;

  always @(posedge clk or posedge reset) begin : model
    logic [3:0] s;
    logic       commit;
    logic [3:0] kc;
    logic       xfer;
    if (reset) begin
      mcnt = 0; mrow = 0; mmode = 0; mrun = 0; mlat_row = 0;
      mlat = 4'hF; ms1 = 4'hF; ms2 = 4'hF;
      mvalid = 1'b0; mcode = 4'h0; movr = 1'b0;
    end else begin
      commit = 1'b0;
      kc = 4'h0;
      if (mcnt == TD - 1) begin
        s = ms2;
        case (mmode)
          0: if ($countones(~s) == 1) begin
               mlat = s; mlat_row = mrow; mrun = 1; mmode = 1;
             end else mrow = (mrow + 1) % 4;
          1: if (s == mlat) mrun++;
             else begin mmode = 0; mrow = (mrow + 1) % 4; end
          2: if (s == 4'hF) begin mrun = 1; mmode = 3; end
          3: if (s == 4'hF) mrun++;
             else mmode = 2;
          default: ;
        endcase
        if (mmode == 1 && mrun == DB) begin
          commit = 1'b1;
          kc = keyval(mlat_row, mlat);
          mmode = 2;
        end
        if (mmode == 3 && mrun == DB) begin
          mmode = 0;
          mrow = (mrow + 1) % 4;
        end
      end
      mcnt = (mcnt + 1) % TD;
      xfer = mvalid && keyReady;
      movr = commit && mvalid && !xfer;
      if (commit && !movr) begin
        mvalid = 1'b1;
        mcode = kc;
      end else if (xfer) begin
        mvalid = 1'b0;
      end
      ms2 = ms1;
      ms1 = cols;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("rows", rows, row_drive(mrow));
      chk("keyValid", keyValid, mvalid);
      chk("overrun", overrun, movr);
      if (mvalid) chk("keyCode", keyCode, mcode);
    end
  end

  // ---------------- event monitor ----------------
  int         pcnt = 0;
  int         rises = 0, ovr_cnt = 0, row_changes = 0;
  int         hi_run = 0, max_run = 0;
  logic [3:0] last_code = 4'h0;
  logic       pv = 1'b0;
  logic [3:0] prow = 4'b1110;

  always @(posedge clk) begin
    if (reset) begin
      pcnt = 0;
      pv = 1'b0;
      prow = 4'b1110;
      hi_run = 0;
    end else begin
      pcnt++;
      if (keyValid && !pv) rises++;
      if (keyValid) begin
        last_code = keyCode;
        hi_run++;
        if (hi_run > max_run) max_run = hi_run;
      end else hi_run = 0;
      if (overrun) ovr_cnt++;
      if (rows != prow) row_changes++;
      pv = keyValid;
      prow = rows;
    end
  end

  task automatic wait_row(input int r);
    logic [3:0] prev;
    bit         ok;
    ok = 0;
    prev = rows;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rows == row_drive(r) && prev != row_drive(r)) ok = 1;
      prev = rows;
    end
    chk("wait_row_timeout", ok, 1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int r0, o0, rc0;

  initial begin
    // Reset values
    reset = 1'b1;
    cyc(3);
    chk("rst_rows", rows, 4'b1110);
    chk("rst_valid", keyValid, 0);
    chk("rst_code", keyCode, 4'h0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    cyc(20);

    // Reset mid-scan, then row sequence every 8 cycles
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rows", rows, 4'b1110);
    chk("midrst_valid", keyValid, 0);
    reset = 1'b0;
    cyc(7);
    chk("seq_hold0", rows, 4'b1110);
    cyc(1);
    chk("seq_row1", rows, 4'b1101);
    cyc(8);
    chk("seq_row2", rows, 4'b1011);
    cyc(8);
    chk("seq_row3", rows, 4'b0111);
    cyc(8);
    chk("seq_wrap", rows, 4'b1110);

    // Clean press of row 1 col 2 -> '6'
    keyReady = 1'b1;
    r0 = rises;
    max_run = 0;
    keys = 16'h1 << 6;
    cyc(80);
    chk("press_rises", rises - r0, 1);
    chk("press_code", last_code, 4'h6);
    chk("press_pulse_len", max_run, 1);
    chk("press_frozen", rows, 4'b1101);
    cyc(40);
    chk("hold_quiet", rises - r0, 1);
    keys = 16'h0;
    cyc(60);

    // Bounce: removed before the second debounce tick
    wait_row(1);
    r0 = rises;
    keys = 16'h1 << 6;
    cyc(8);
    keys = 16'h0;
    cyc(8);
    chk("bounce_row2", rows, 4'b1011);
    cyc(40);
    chk("bounce_no_key", rises - r0, 0);

    // Two keys on one row -> cols 1001, not a press
    r0 = rises;
    rc0 = row_changes;
    keys = (16'h1 << 1) | (16'h1 << 2);
    cyc(80);
    chk("twokey_no_key", rises - r0, 0);
    chk("twokey_scanning", (row_changes - rc0) >= 9, 1);
    keys = 16'h0;
    cyc(20);

    // Backpressure: '5' buffered, '9' dropped with overrun
    keyReady = 1'b0;
    r0 = rises;
    o0 = ovr_cnt;
    keys = 16'h1 << 5;
    cyc(80);
    keys = 16'h0;
    cyc(80);
    keys = 16'h1 << 10;
    cyc(80);
    keys = 16'h0;
    cyc(80);
    chk("bp_valid", keyValid, 1);
    chk("bp_code", keyCode, 4'h5);
    chk("bp_overrun", ovr_cnt - o0, 1);
    chk("bp_rises", rises - r0, 1);
    keyReady = 1'b1;
    @(negedge clk);
    chk("bp_drain", keyValid, 0);
    cyc(20);

    // Release glitch: one-tick re-press during release
    r0 = rises;
    keys = 16'h1 << 6;
    cyc(80);
    chk("glitch_first", rises - r0, 1);
    while (pcnt % TD != 0) @(negedge clk);
    keys = 16'h0;
    cyc(8);
    keys = 16'h1 << 6;
    cyc(8);
    keys = 16'h0;
    chk("glitch_frozen", rows, 4'b1101);
    cyc(60);
    chk("glitch_single", rises - r0, 1);
    keys = 16'h1 << 6;
    cyc(80);
    chk("glitch_repress", rises - r0, 2);
    keys = 16'h0;
    cyc(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. It paces the row scan from a divided tick and freezes the scan on a candidate key. It debounces the press and release over whole scan ticks, then hands each accepted key to the downstream datapath through a one-entry valid/ready buffer. It sits between the keypad pins and the display/segment logic, and replaces free-running row selection with a sequenced scan.

## Interface
Parameters:
- TICK_DIV, 48000: clk cycles per scan tick (≥ 4); sets the row dwell and column settle time.
- DEBOUNCE_SCANS, 3: consecutive matching ticks required to accept a press or a release (≥ 1, ≤ 15).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- cols  in  4  raw keypad columns, active-low, asynchronous to clk.
- rows  out  4  row drive, active-low one-hot.
- keyCode  out  4  hex value of the buffered key; stable while keyValid is high.
- keyValid  out  1  buffer holds a key.
- keyReady  in  1  consumer accepts; transfer occurs when keyValid & keyReady.
- overrun  out  1  one-cycle pulse when an accepted key is dropped because the buffer is full.

## Operation
- cols pass through a 2-flop synchronizer, giving colsS. All decisions use colsS at tick cycles only.
- **Tick generation:**
  - The counter runs 0..TICK_DIV-1.
  - tick is high for the one cycle where the counter equals TICK_DIV-1.
  - The counter then wraps to 0.
- **Row index rowIdx (0..3):**
  - Advances by 1 on tick, wrapping 3→0, only in state SCAN.
  - rows = ~(4'b1 << rowIdx).
- **Valid press:** colsS has exactly one zero bit. colIdx is the position of that bit. Zero-free or multi-zero patterns are not presses.
- **FSM states and transitions (evaluated on tick):**
  - SCAN:
    - Valid press: latch rowIdx and colsS, set dbCnt=1, go to DEBOUNCE. The row does not advance.
    - Otherwise: stay in SCAN and advance the row.
  - DEBOUNCE:
    - colsS equals the latched pattern: dbCnt++. When dbCnt reaches DEBOUNCE_SCANS, commit the key and go to HELD.
    - Any mismatch: go to SCAN and advance the row.
  - HELD:
    - colsS == 4'hF: set dbCnt=1 and go to RELEASE.
    - Otherwise: stay in HELD. Rolling to a different key emits nothing.
  - RELEASE:
    - colsS == 4'hF: dbCnt++. When dbCnt reaches DEBOUNCE_SCANS, go to SCAN and advance the row.
    - Otherwise: return to HELD. No new key is emitted.
- **DEBOUNCE_SCANS = 1:** commit or release happens on the entering tick itself (SCAN→HELD, HELD→SCAN directly).
- **Commit:** keyCode_next = KEYMAP[{row, col}].
  - Buffer empty, or transfer in the same cycle: load the buffer and set keyValid.
  - Buffer full and no transfer: drop the key and pulse overrun. The buffer is unchanged.
- **Transfer:** keyValid clears on the cycle after keyValid & keyReady, unless a commit loads in that same cycle.
- keyReady while keyValid is low is ignored.

## Timing
- **Reset values:**
  - state SCAN, counter 0, rowIdx 0, rows = 4'b1110, dbCnt 0.
  - keyValid 0, keyCode 4'h0, overrun 0.
  - Synchronizer flops reset to 4'hF.
- Reset mid-operation returns everything to the reset values immediately. A pending buffered key is lost.
- Row dwell is exactly TICK_DIV cycles, so cols have TICK_DIV-1 cycles to settle before sampling.
- Input latency is 2 cycles (synchronizer). A change must precede the tick edge by ≥ 2 cycles to be seen on that tick.
- Press-to-keyValid is DEBOUNCE_SCANS-1 ticks after the detecting tick, plus 1 cycle. keyValid rises the cycle after the committing tick.
- overrun is registered and aligned with the cycle keyValid would have loaded.
- All outputs are registered; no combinational path from cols or keyReady to any output.

## Structure
- Package keypad_pkg:
  - typedef enum scan_state_t {SCAN, DEBOUNCE, HELD, RELEASE}.
  - constant KEYMAP[16], indexed {row, col}. Rows in order: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
  - constant COLS_IDLE = 4'hF.
- Sub-module scan_timer: owns the tick counter and emits the one-cycle tick. Parameter TICK_DIV; ports clk, reset, tick.
- Top-level content: synchronizer, FSM, row/latch registers, output buffer.

## Test plan
Bench uses TICK_DIV=8, DEBOUNCE_SCANS=3.
- Reset mid-scan: rows is 4'b1110 during reset; after release, rows steps 1110→1101→1011→0111→1110 every 8 cycles.
- Clean press of row 1, col 2 (cols=4'b1011 while rows=4'b1101), keyReady=1:
  - Scan freezes on row 1.
  - keyCode=4'h6 and keyValid pulses high for 1 cycle, 2 ticks + 1 cycle after detection.
  - Holding the key emits nothing further.
- Bounce: press removed on the 2nd debounce tick → no keyValid, and scanning resumes at row 2.
- Two-key press (cols=4'b1001) → no keyValid; scan continues.
- Backpressure:
  - keyReady=0; press/release key '5', then press/release key '9'.
  - keyValid stays high with keyCode=4'h5, and overrun pulses once at the '9' commit.
  - Raising keyReady clears keyValid the next cycle.
- Release glitch: in RELEASE, cols return to 1011 for one tick → back to HELD; no second keyValid until a full release followed by a new press.
